inst_fetch_responder: RTL and testbench

- Memory-side responder to the frontend PC controller's fetch request (pc_index / pc_index_valid / pc_index_done).
- Accepts a 19-bit 8-byte-granular index, issues a single DDR read burst of BEATS 64-bit beats, and assembles a 512-bit instruction line.
- Returns the line with a one-cycle pc_index_done pulse.
- Sits between pc_ctrl and the DDR read port; supports flush on redirect (interrupt).

---
 rtl/inst_fetch_responder.sv | 144 ++++++++++++++
 tb/tb_inst_fetch_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Fetch responder: turns a pc_ctrl index request into one DDR burst and returns a 64*BEATS-bit line.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module inst_fetch_responder #(
  parameter int BEATS = 8,
  parameter int IDX_W = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_index_valid,
  input  logic [IDX_W-1:0]      pc_index,
  input  logic                  flush,
  output logic                  pc_index_done,
  output logic [64*BEATS-1:0]   fetch_line,
  output logic                  fetch_line_valid,
  output logic                  ddr_rd_req,
  output logic [IDX_W-1:0]      ddr_rd_addr,
  input  logic                  ddr_rd_ready,
  input  logic                  ddr_rd_data_valid,
  input  logic [63:0]           ddr_rd_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
  output logic [15:0]           perf_flush_cnt
`endif
);

  localparam int LINE_W = 64 * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_REQ, S_RECV, S_DONE, S_DRAIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [LINE_W-1:0]  line_buf;
  logic [LINE_W-1:0]  line_next;
  logic               skip_idle;
  logic               last_beat;

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    line_next = line_buf;
    line_next[int'(beat_cnt)*64 +: 64] = ddr_rd_data;
  end

  // skip_idle masks the requester's late valid drop in the IDLE cycle after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      beat_cnt         <= '0;
      line_buf         <= '0;
      skip_idle        <= 1'b0;
      pc_index_done    <= 1'b0;
      fetch_line       <= '0;
      fetch_line_valid <= 1'b0;
      ddr_rd_req       <= 1'b0;
      ddr_rd_addr      <= '0;
    end else begin
      pc_index_done    <= 1'b0;
      fetch_line_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          skip_idle <= 1'b0;
          if (pc_index_valid && !skip_idle && !flush) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (flush || !pc_index_valid) begin
            state <= S_IDLE;
          end else begin
            ddr_rd_addr <= pc_index;
            ddr_rd_req  <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (ddr_rd_ready) begin
            ddr_rd_req <= 1'b0;
            beat_cnt   <= '0;
            state      <= flush ? S_DRAIN : S_RECV;
          end else if (flush) begin
            ddr_rd_req <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_RECV: begin
          if (ddr_rd_data_valid) begin
            line_buf <= line_next;
            if (last_beat) begin
              beat_cnt <= '0;
              if (flush) begin
                state <= S_IDLE;
              end else begin
                fetch_line       <= line_next;
                pc_index_done    <= 1'b1;
                fetch_line_valid <= 1'b1;
                state            <= S_DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (flush) state <= S_DRAIN;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ddr_rd_data_valid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          skip_idle <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_index_done) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == S_REQ || state == S_RECV) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
        if (flush) perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: stimulus pushes expected addresses/lines, a monitor pops and compares.
module tb_inst_fetch_responder;

  localparam int BEATS = 8;
  localparam int IDX_W = 19;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 pc_index_valid = 1'b0;
  logic [IDX_W-1:0]     pc_index = '0;
  logic                 flush = 1'b0;
  logic                 pc_index_done;
  logic [64*BEATS-1:0]  fetch_line;
  logic                 fetch_line_valid;
  logic                 ddr_rd_req;
  logic [IDX_W-1:0]     ddr_rd_addr;
  logic                 ddr_rd_ready = 1'b0;
  logic                 ddr_rd_data_valid = 1'b0;
  logic [63:0]          ddr_rd_data = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]          perf_fetch_cnt;
  logic [31:0]          perf_stall_cnt;
  logic [15:0]          perf_flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [IDX_W-1:0]    exp_addr[$];
  logic [64*BEATS-1:0] exp_line[$];
  logic [64*BEATS-1:0] last_line = '0;

  inst_fetch_responder #(.BEATS(BEATS), .IDX_W(IDX_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_index_valid    (pc_index_valid),
    .pc_index          (pc_index),
    .flush             (flush),
    .pc_index_done     (pc_index_done),
    .fetch_line        (fetch_line),
    .fetch_line_valid  (fetch_line_valid),
    .ddr_rd_req        (ddr_rd_req),
    .ddr_rd_addr       (ddr_rd_addr),
    .ddr_rd_ready      (ddr_rd_ready),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .ddr_rd_data       (ddr_rd_data)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [64*BEATS-1:0] act, input logic [64*BEATS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DDR accept and every done pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ddr_rd_req && ddr_rd_ready) begin
        if (exp_addr.size() == 0) chk("unexpected_accept", 1, 0);
        else chk("ddr_rd_addr", ddr_rd_addr, exp_addr.pop_front());
      end
      if (pc_index_done) begin
        if (exp_line.size() == 0) chk("unexpected_done", 1, 0);
        else chk("fetch_line", fetch_line, exp_line.pop_front());
      end
      chk("valid_matches_done", fetch_line_valid, pc_index_done);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [IDX_W-1:0] idx, input int rdy_delay);
    exp_addr.push_back(idx);
    ddr_rd_ready   = (rdy_delay == 0);
    pc_index_valid = 1'b1;
    step;
    pc_index = idx;
    step;
    for (int i = 0; i < rdy_delay; i++) begin
      chk("req_held", ddr_rd_req, 1);
      step;
    end
    ddr_rd_ready = 1'b1;
    chk("req_at_accept", ddr_rd_req, 1);
    step;
    chk("req_drop", ddr_rd_req, 0);
  endtask

  task automatic send_beats(input logic [63:0] base, input logic [63:0] stepv,
                            input int first, input int n, input int gap);
    for (int k = first; k < first + n; k++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = base + stepv * 64'(k);
      step;
      ddr_rd_data_valid = 1'b0;
      if (k != first + n - 1) repeat (gap) step;
    end
  endtask

  task automatic do_fetch(input logic [IDX_W-1:0] idx, input logic [63:0] base, input logic [63:0] stepv,
                          input int rdy_delay, input int gap, input bit hold_late);
    logic [64*BEATS-1:0] line;
    for (int k = 0; k < BEATS; k++) line[k*64 +: 64] = base + stepv * 64'(k);
    exp_line.push_back(line);
    last_line = line;
    start_req(idx, rdy_delay);
    send_beats(base, stepv, 0, BEATS, gap);
    chk("done_timing", pc_index_done, 1);
    if (hold_late) begin
      step;
      chk("done_single", pc_index_done, 0);
      step;
      pc_index_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk("no_second_req", ddr_rd_req, 0);
        step;
      end
    end else begin
      pc_index_valid = 1'b0;
      step;
    end
    repeat (2) step;
  endtask

  initial begin
    #2;
    chk("rst_done", pc_index_done, 0);
    chk("rst_line", fetch_line, 0);
    chk("rst_line_valid", fetch_line_valid, 0);
    chk("rst_req", ddr_rd_req, 0);
    chk("rst_addr", ddr_rd_addr, 0);
    repeat (3) step;
    rst_n = 1'b1;
    repeat (2) step;

    // Basic fetch with valid held late through done and the following cycle
    do_fetch(19'h00010, 64'h0, 64'h1111_1111_1111_1111, 0, 0, 1'b1);
    chk("beat0_slice", fetch_line[63:0], 64'h0);
    chk("beat7_slice", fetch_line[511:448], 64'h7777_7777_7777_7777);

    // Backpressure (ready low 5 cycles) and one-cycle gaps between beats
    do_fetch(19'h00200, 64'hB000_0000_0000_0000, 64'h0000_0001_0000_0001, 5, 1, 1'b0);

    // Flush after 3 beats; drain 5 more; line must be unchanged
    start_req(19'h00300, 0);
    send_beats(64'hDEAD_0000_0000_0000, 64'h1, 0, 3, 0);
    flush = 1'b1;
    pc_index_valid = 1'b0;
    step;
    flush = 1'b0;
    chk("flush_no_req", ddr_rd_req, 0);
    send_beats(64'hDEAD_0000_0000_0000, 64'h1, 3, 5, 0);
    chk("flush_no_done", pc_index_done, 0);
    chk("flush_line_kept", fetch_line, last_line);
    repeat (2) step;
    do_fetch(19'h00400, 64'h4000_0000_0000_0400, 64'h10, 0, 0, 1'b0);

    // Index near the top of the range; no alignment or clamping
    do_fetch(19'h7FFFC, 64'hA5A5_0000_0007_FFFC, 64'h1, 0, 0, 1'b0);
    chk("wrap_beat3", fetch_line[255:192], 64'hA5A5_0000_0007_FFFF);
    chk("wrap_beat4", fetch_line[319:256], 64'hA5A5_0000_0008_0000);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 4);
    chk("perf_flush_cnt", perf_flush_cnt, 1);
`endif

    // Reset in the middle of RECV
    start_req(19'h00123, 0);
    send_beats(64'h5555_0000_0000_0000, 64'h1, 0, 4, 0);
    rst_n = 1'b0;
    pc_index_valid = 1'b0;
    #1;
    chk("mid_rst_line", fetch_line, 0);
    chk("mid_rst_req", ddr_rd_req, 0);
    chk("mid_rst_addr", ddr_rd_addr, 0);
    chk("mid_rst_done", pc_index_done, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_fetch", perf_fetch_cnt, 0);
    chk("mid_rst_perf_stall", perf_stall_cnt, 0);
    chk("mid_rst_perf_flush", perf_flush_cnt, 0);
`endif
    step;
    rst_n = 1'b1;
    step;
    send_beats(64'h5555_0000_0000_0000, 64'h1, 4, 4, 0);
    repeat (2) step;
    chk("post_rst_line", fetch_line, 0);
    chk("post_rst_req", ddr_rd_req, 0);

    // Recovery fetch after reset
    do_fetch(19'h00055, 64'hC0DE_0000_0000_0000, 64'h3, 0, 0, 1'b0);

    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("line_queue_empty", exp_line.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
